// File: rtl/tsp16_pkg.sv
// Shared TSP16 request-bus types used by the one-hot index encoder and its picker.
package tsp16_pkg;

  localparam int unsigned REQ_N     = 8;
  localparam int unsigned REQ_IDX_W = $clog2(REQ_N);

  typedef logic [$clog2(REQ_N)-1:0] req_idx_t;
  typedef logic [REQ_N-1:0]         req_vec_t;

  // Output stage occupancy: EMPTY means no index presented, FULL means idx is valid.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage : tsp16_pkg

// File: rtl/onehot_rr_pick.sv
// Combinational picker: first set pending bit searching upward from last+1 with wrap-around.
module onehot_rr_pick
  import tsp16_pkg::*;
#(
  parameter  int unsigned N     = REQ_N,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick,
  output logic [N-1:0]     pick_oh,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] pos;
    pos     = '0;
    pick    = '0;
    pick_oh = '0;
    any     = 1'b0;
    // N is a power of two, so IDX_W-bit wrap-around gives the modulo for free.
    for (int unsigned i = 0; i < N; i++) begin
      pos = IDX_W'(last + IDX_W'(1) + IDX_W'(i));
      if (!any && pending[pos]) begin
        any  = 1'b1;
        pick = pos;
      end
    end
    pick_oh[pick] = any;
  end

endmodule : onehot_rr_pick

// File: rtl/onehot_index_encoder.sv
// Sticky multi-hot request collector that hands out one binary index per valid/ready transfer.
// Define ONEHOT_ROUND_ROBIN_EN for rotating priority; otherwise the lowest pending bit wins.
module onehot_index_encoder
  import tsp16_pkg::*;
#(
  parameter  int unsigned N     = REQ_N,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             flush,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [N-1:0]     pending
);

  out_state_e       state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] pick_base;
  logic [IDX_W-1:0] pick;
  logic [N-1:0]     pick_oh;
  logic             pick_any;
  logic             load;

`ifdef ONEHOT_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDX_W'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

  assign pick_base = last_q;
`else
  // Fixed priority: a constant base of N-1 makes the search start at bit 0.
  assign pick_base = IDX_W'(N - 1);
`endif

  onehot_rr_pick #(
    .N (N)
  ) u_pick (
    .pending (pending_q),
    .last    (pick_base),
    .pick    (pick),
    .pick_oh (pick_oh),
    .any     (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OUT_EMPTY;
      pending_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
    end
  end

  // Next-state: flush dominates; otherwise load whenever the output slot is free or draining.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    load      = 1'b0;
`ifdef ONEHOT_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    if (flush) begin
      state_d   = OUT_EMPTY;
      pending_d = '0;
    end else begin
      load      = ((state_q == OUT_EMPTY) || idx_ready) && pick_any;
      pending_d = (pending_q & ~(load ? pick_oh : '0)) | req;
      case (state_q)
        OUT_EMPTY: if (pick_any) state_d = OUT_FULL;
        OUT_FULL:  if (idx_ready) state_d = pick_any ? OUT_FULL : OUT_EMPTY;
        default:   state_d = OUT_EMPTY;
      endcase
      if (load) begin
        idx_d  = pick;
`ifdef ONEHOT_ROUND_ROBIN_EN
        last_d = pick;
`endif
      end
    end
  end

  assign idx       = idx_q;
  assign idx_valid = (state_q == OUT_FULL);
  assign pending   = pending_q;

endmodule : onehot_index_encoder

// File: tb/tb_onehot_index_encoder.sv
// Directed bench for onehot_index_encoder with a cycle-level behavioural model and literal pins.
module tb_onehot_index_encoder;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         flush;
  logic [2:0]   idx;
  logic         idx_valid;
  logic         idx_ready;
  logic [N-1:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  onehot_index_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .flush     (flush),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a set of pending bits, one presented slot, and a rotating start point.
  bit [N-1:0] m_pend;
  bit         m_valid;
  int         m_idx;
  int         m_last;
  int         pk;
  int         j;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_last  = N - 1;
    end else if (flush) begin
      m_pend  = '0;
      m_valid = 1'b0;
    end else begin
      pk = -1;
      for (int k = 0; k < N; k++) begin
`ifdef ONEHOT_ROUND_ROBIN_EN
        j = (m_last + 1 + k) % N;
`else
        j = k;
`endif
        if (pk < 0 && m_pend[j]) pk = j;
      end
      if (pk >= 0 && (!m_valid || idx_ready)) begin
        m_pend[pk] = 1'b0;
        m_idx      = pk;
        m_valid    = 1'b1;
        m_last     = pk;
      end else if (m_valid && idx_ready) begin
        m_valid = 1'b0;
      end
      m_pend = m_pend | req;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_valid", 32'(idx_valid), 32'(m_valid));
      if (m_valid) chk("model_idx", 32'(idx), 32'(m_idx));
      chk("model_pending", 32'(pending), 32'(m_pend));
    end
  end

  task automatic step(input logic [N-1:0] r, input logic rdy, input logic fl);
    req       = r;
    idx_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; flush = 1'b0; idx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(idx_valid), 32'd0);
    chk("reset_idx", 32'(idx), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    rst_n = 1'b1;

    // Single request: idx 2 two edges later for one cycle.
    step(8'b0000_0100, 1'b1, 1'b0);
    chk("t1_pending", 32'(pending), 32'h04);
    chk("t1_valid_early", 32'(idx_valid), 32'd0);
    step('0, 1'b1, 1'b0);
    chk("t1_valid", 32'(idx_valid), 32'd1);
    chk("t1_idx", 32'(idx), 32'd2);
    chk("t1_pending_after", 32'(pending), 32'd0);
    step('0, 1'b1, 1'b0);
    chk("t1_valid_drop", 32'(idx_valid), 32'd0);

    // Multi-hot burst: 0, 4, 7 back to back.
    step(8'b1001_0001, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("t2_idx0", 32'(idx), 32'd0);
    step('0, 1'b1, 1'b0);
    chk("t2_idx4", 32'(idx), 32'd4);
    step('0, 1'b1, 1'b0);
    chk("t2_idx7", 32'(idx), 32'd7);
    chk("t2_valid7", 32'(idx_valid), 32'd1);
    step('0, 1'b1, 1'b0);
    chk("t2_empty", 32'(idx_valid), 32'd0);

    // Priority difference: after serving 2, bits {0,4} go to 4 first only when rotating.
    step(8'b0000_0100, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    step(8'b0001_0001, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
`ifdef ONEHOT_ROUND_ROBIN_EN
    chk("t3_first", 32'(idx), 32'd4);
`else
    chk("t3_first", 32'(idx), 32'd0);
`endif
    step('0, 1'b1, 1'b0);
`ifdef ONEHOT_ROUND_ROBIN_EN
    chk("t3_second", 32'(idx), 32'd0);
`else
    chk("t3_second", 32'(idx), 32'd4);
`endif
    step('0, 1'b1, 1'b0);
    chk("t3_empty", 32'(idx_valid), 32'd0);

    // Stall: idx 3 held while bit 5 arrives, then 5 follows the accept.
    step(8'b0000_1000, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("t4_idx3", 32'(idx), 32'd3);
    step(8'b0010_0000, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("t4_hold_idx", 32'(idx), 32'd3);
    chk("t4_hold_valid", 32'(idx_valid), 32'd1);
    chk("t4_hold_pending", 32'(pending), 32'h20);
    step('0, 1'b1, 1'b0);
    chk("t4_idx5", 32'(idx), 32'd5);
    chk("t4_pending_clear", 32'(pending), 32'd0);
    step('0, 1'b1, 1'b0);
    chk("t4_empty", 32'(idx_valid), 32'd0);

    // Continuous request on bit 6: presented every cycle with nothing lost.
    step(8'b0100_0000, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(8'b0100_0000, 1'b1, 1'b0);
      chk("t5_idx6", 32'(idx), 32'd6);
      chk("t5_valid", 32'(idx_valid), 32'd1);
    end
    step('0, 1'b1, 1'b0);
    chk("t5_last_idx", 32'(idx), 32'd6);
    step('0, 1'b1, 1'b0);
    chk("t5_empty", 32'(idx_valid), 32'd0);

    // Flush with a presented index and two pending bits; request in the flush cycle is dropped.
    step(8'b1100_0000, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(8'b1100_0000, 1'b0, 1'b0);
    chk("t6_pre_pending", 32'(pending), 32'hC0);
    chk("t6_pre_valid", 32'(idx_valid), 32'd1);
    step(8'b0000_0001, 1'b0, 1'b1);
    chk("t6_flush_pending", 32'(pending), 32'd0);
    chk("t6_flush_valid", 32'(idx_valid), 32'd0);
    step('0, 1'b0, 1'b0);
    chk("t6_stay_empty", 32'(idx_valid), 32'd0);

    // Async reset in the middle of a stall.
    step(8'b0000_0010, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(8'b0000_1000, 1'b0, 1'b0);
    chk("t7_stall_valid", 32'(idx_valid), 32'd1);
    chk("t7_stall_idx", 32'(idx), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(idx_valid), 32'd0);
    chk("t7_rst_idx", 32'(idx), 32'd0);
    chk("t7_rst_pending", 32'(pending), 32'd0);
    req = '0; idx_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // After reset the search starts from bit 0 again.
    step(8'b1000_0001, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("t8_idx0", 32'(idx), 32'd0);
    step('0, 1'b1, 1'b0);
    chk("t8_idx7", 32'(idx), 32'd7);
    step('0, 1'b1, 1'b0);
    chk("t8_empty", 32'(idx_valid), 32'd0);
    step('0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_onehot_index_encoder
